riscv_data_mem_wait: RTL and testbench

//  Parametrised data memory for the RISC-V processor family: replaces the testbench word-only array model.

---
 rtl/riscv_mem_pkg.sv | 14 +
 rtl/mem_lane_align.sv | 62 ++++++
 rtl/riscv_data_mem_wait.sv | 146 ++++++++++++++
 tb/tb_riscv_data_mem_wait.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the RISC-V data memory: access sizes and controller states.
package riscv_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for sub-word accesses: store byte enables/replication,
// load lane extraction with sign/zero extension, and alignment check.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        load_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] load_ext,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword[7:0];
    case (addr_lo)
      2'd0: byte_sel = rword[7:0];
      2'd1: byte_sel = rword[15:8];
      2'd2: byte_sel = rword[23:16];
      2'd3: byte_sel = rword[31:24];
      default: byte_sel = rword[7:0];
    endcase
    half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    byte_en    = 4'b0000;
    wword      = wdata;
    load_ext   = '0;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        byte_en  = 4'b0001 << addr_lo;
        wword    = {4{wdata[7:0]}};
        load_ext = load_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        byte_en    = 4'b0011 << addr_lo;
        wword      = {2{wdata[15:0]}};
        load_ext   = load_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      SIZE_WORD: begin
        byte_en    = 4'b1111;
        wword      = wdata;
        load_ext   = rword;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        byte_en  = 4'b0000;
        load_ext = '0;
      end
    endcase
  end

endmodule

// File: rtl/riscv_data_mem_wait.sv
// Data memory with byte/half/word access, programmable wait states and
// valid/ready request/response handshakes; one transaction outstanding.
//
// state   | meaning
// IDLE    | req_ready=1, waiting for a request
// WAIT    | request latched, counting down wait states
// RESP    | response held on resp_* until resp_ready
module riscv_data_mem_wait
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int WAIT_STATES = 0,
  parameter int INIT_ZERO   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH_WORDS);
  localparam logic [31:0] MEM_INIT   = (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;

  mem_state_e  state_q, state_d;
  logic [3:0]  cnt_q;
  logic        lat_write, lat_unsigned;
  logic [31:0] lat_addr, lat_wdata;
  logic [1:0]  lat_size;

  logic        eff_write, eff_unsigned;
  logic [31:0] eff_addr, eff_wdata;
  logic [1:0]  eff_size;

  logic [3:0]  byte_en;
  logic [31:0] wword, load_ext, rword;
  logic        misaligned, out_of_range, err, enter_resp;
  logic [AW-1:0] word_idx;

  logic [31:0] mem [DEPTH_WORDS] = '{default: MEM_INIT};

  // In IDLE the live request is used so a zero-wait access can complete on its accept edge.
  always_comb begin
    if (state_q == ST_IDLE) begin
      eff_write    = req_write;
      eff_unsigned = req_unsigned;
      eff_addr     = req_addr;
      eff_wdata    = req_wdata;
      eff_size     = req_size;
    end else begin
      eff_write    = lat_write;
      eff_unsigned = lat_unsigned;
      eff_addr     = lat_addr;
      eff_wdata    = lat_wdata;
      eff_size     = lat_size;
    end
  end

  assign word_idx     = eff_addr[AW+1:2];
  assign rword        = mem[word_idx];
  assign out_of_range = ({1'b0, eff_addr} >= BYTE_LIMIT);
  assign err          = misaligned | out_of_range | (eff_size == 2'b11);
  assign enter_resp   = (state_q != ST_RESP) && (state_d == ST_RESP);

  mem_lane_align u_align (
    .size          (eff_size),
    .addr_lo       (eff_addr[1:0]),
    .load_unsigned (eff_unsigned),
    .wdata         (eff_wdata),
    .rword         (rword),
    .byte_en       (byte_en),
    .wword         (wword),
    .load_ext      (load_ext),
    .misaligned    (misaligned)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_size     <= SIZE_BYTE;
      resp_rdata   <= '0;
      resp_error   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && req_valid) begin
        lat_write    <= req_write;
        lat_unsigned <= req_unsigned;
        lat_addr     <= req_addr;
        lat_wdata    <= req_wdata;
        lat_size     <= req_size;
        cnt_q        <= 4'(WAIT_STATES - 1);
      end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (enter_resp) begin
        resp_error <= err;
        resp_rdata <= (err || eff_write) ? 32'h0 : load_ext;
      end
    end
  end

  // Storage has no reset; the reset term only blocks a commit while reset is held.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && eff_write && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_data_mem_wait.sv
// Directed bench for riscv_data_mem_wait: a zero-wait and a three-wait instance,
// expected responses queued at issue and compared when the response appears.
module tb_riscv_data_mem_wait;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset        [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_write    [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic        resp_valid   [2];
  logic        resp_ready   [2];
  logic [31:0] resp_rdata   [2];
  logic        resp_error   [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  riscv_data_mem_wait #(.DEPTH_WORDS(2048), .WAIT_STATES(0), .INIT_ZERO(1)) u_dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
  );

  riscv_data_mem_wait #(.DEPTH_WORDS(2048), .WAIT_STATES(3), .INIT_ZERO(1)) u_dut3 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input int inst);
    return (inst == 0) ? 0 : 3;
  endfunction

  // Issue one request, check latency, compare against the queued expectation,
  // optionally hold off resp_ready for 'hold' cycles, then complete the handshake.
  task automatic xact(input int inst, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                      input logic [31:0] erd, input logic eerr, input int hold,
                      input string tag);
    int          lat;
    bit          seen;
    exp_t        e;
    logic [31:0] rd0;
    logic        er0;
    sb_q.push_back('{inst, erd, eerr});
    @(negedge clk);
    chk({tag, "_req_ready"}, 32'(req_ready[inst]), 32'd1);
    req_valid[inst]    = 1'b1;
    req_write[inst]    = wr;
    req_addr[inst]     = addr;
    req_wdata[inst]    = wdata;
    req_size[inst]     = size;
    req_unsigned[inst] = uns;
    @(posedge clk);
    @(negedge clk);
    req_valid[inst]    = 1'b0;
    req_write[inst]    = 1'($urandom);
    req_addr[inst]     = $urandom;
    req_wdata[inst]    = $urandom;
    req_size[inst]     = 2'($urandom);
    req_unsigned[inst] = 1'($urandom);
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid[inst]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    chk({tag, "_resp_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, 32'(lat), 32'(1 + ws_of(inst)));
      chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk({tag, "_sb_inst"}, 32'(inst), 32'(e.inst));
        chk({tag, "_rdata"}, resp_rdata[inst], e.rdata);
        chk({tag, "_error"}, 32'(resp_error[inst]), 32'(e.err));
      end
      rd0 = resp_rdata[inst];
      er0 = resp_error[inst];
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({tag, "_hold_valid"}, 32'(resp_valid[inst]), 32'd1);
        chk({tag, "_hold_ready"}, 32'(req_ready[inst]), 32'd0);
        chk({tag, "_hold_rdata"}, resp_rdata[inst], rd0);
        chk({tag, "_hold_error"}, 32'(resp_error[inst]), 32'(er0));
      end
      chk({tag, "_ready_in_resp"}, 32'(req_ready[inst]), 32'd0);
      resp_ready[inst] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready[inst] = 1'b0;
      chk({tag, "_valid_drop"}, 32'(resp_valid[inst]), 32'd0);
      chk({tag, "_ready_back"}, 32'(req_ready[inst]), 32'd1);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b0; req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_size[k] = SIZE_WORD; req_unsigned[k] = 1'b0; resp_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset[0] = 1'b1;
    reset[1] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
      chk("rst_resp_rdata", resp_rdata[k], 32'h0);
      chk("rst_resp_error", 32'(resp_error[k]), 32'd0);
    end

    // word store/load, zero wait
    xact(0, 1, 32'd40, 32'h0000_0140, SIZE_WORD, 0, 32'h0, 0, 0, "sw40");
    xact(0, 0, 32'd40, 32'h0,         SIZE_WORD, 0, 32'h0000_0140, 0, 0, "lw40");

    // byte lanes and extension
    xact(0, 1, 32'd8,  32'h1122_3344, SIZE_WORD, 0, 32'h0, 0, 0, "sw8");
    xact(0, 1, 32'd9,  32'h5A5A_5AF0, SIZE_BYTE, 0, 32'h0, 0, 0, "sb9");
    xact(0, 0, 32'd8,  32'h0,         SIZE_WORD, 0, 32'h1122_F044, 0, 0, "lw8");
    xact(0, 0, 32'd9,  32'h0,         SIZE_BYTE, 0, 32'hFFFF_FFF0, 0, 0, "lb9");
    xact(0, 0, 32'd9,  32'h0,         SIZE_BYTE, 1, 32'h0000_00F0, 0, 0, "lbu9");
    xact(0, 0, 32'd10, 32'h0,         SIZE_HALF, 0, 32'h0000_1122, 0, 0, "lh10");
    xact(0, 1, 32'd12, 32'h8001_0000, SIZE_WORD, 0, 32'h0, 0, 0, "sw12");
    xact(0, 0, 32'd14, 32'h0,         SIZE_HALF, 0, 32'hFFFF_8001, 0, 0, "lh14");
    xact(0, 0, 32'd14, 32'h0,         SIZE_HALF, 1, 32'h0000_8001, 0, 0, "lhu14");
    xact(0, 1, 32'd12, 32'hCCCC_BEEF, SIZE_HALF, 0, 32'h0, 0, 0, "sh12");
    xact(0, 0, 32'd12, 32'h0,         SIZE_WORD, 0, 32'h8001_BEEF, 0, 0, "lw12");

    // misalignment and illegal size
    xact(0, 1, 32'd4, 32'hCAFE_BABE, SIZE_WORD, 0, 32'h0, 0, 0, "sw4");
    xact(0, 1, 32'd6, 32'h1234_5678, SIZE_WORD, 0, 32'h0, 1, 0, "sw6_mis");
    xact(0, 0, 32'd4, 32'h0,         SIZE_WORD, 0, 32'hCAFE_BABE, 0, 0, "lw4_kept");
    xact(0, 0, 32'd3, 32'h0,         SIZE_HALF, 0, 32'h0, 1, 0, "lh3_mis");
    xact(0, 0, 32'd4, 32'h0,         2'b11,     0, 32'h0, 1, 0, "ld_size3");
    xact(0, 1, 32'd4, 32'h0000_0000, 2'b11,     0, 32'h0, 1, 0, "st_size3");
    xact(0, 0, 32'd4, 32'h0,         SIZE_WORD, 0, 32'hCAFE_BABE, 0, 0, "lw4_kept2");

    // range limits
    xact(0, 1, 32'd0,    32'h0BAD_F00D, SIZE_WORD, 0, 32'h0, 0, 0, "sw0");
    xact(0, 0, 32'd8192, 32'h0,         SIZE_WORD, 0, 32'h0, 1, 0, "lw8192");
    xact(0, 1, 32'd8192, 32'h7777_7777, SIZE_WORD, 0, 32'h0, 1, 0, "sw8192");
    xact(0, 0, 32'd0,    32'h0,         SIZE_WORD, 0, 32'h0BAD_F00D, 0, 0, "lw0_noalias");
    xact(0, 1, 32'd8188, 32'hA5A5_0F0F, SIZE_WORD, 0, 32'h0, 0, 0, "sw_last");
    xact(0, 0, 32'd8188, 32'h0,         SIZE_WORD, 0, 32'hA5A5_0F0F, 0, 0, "lw_last");
    xact(0, 0, 32'd8191, 32'h0,         SIZE_BYTE, 1, 32'h0000_00A5, 0, 0, "lbu_top");

    // wait states and backpressure
    xact(1, 1, 32'h20, 32'h0000_55AA, SIZE_WORD, 0, 32'h0, 0, 5, "ws_sw20");
    xact(1, 0, 32'h20, 32'h0,         SIZE_WORD, 0, 32'h0000_55AA, 0, 5, "ws_lw20");
    xact(1, 0, 32'h21, 32'h0,         SIZE_WORD, 0, 32'h0, 1, 0, "ws_lw21_mis");

    // reset while a store sits in WAIT
    xact(1, 1, 32'd16, 32'h0000_1111, SIZE_WORD, 0, 32'h0, 0, 0, "ws_sw16");
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'd16;
    req_wdata[1] = 32'hDEAD_BEEF; req_size[1] = SIZE_WORD; req_unsigned[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("midwait_ready_low", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    reset[1] = 1'b0;
    #1;
    chk("midwait_rst_valid", 32'(resp_valid[1]), 32'd0);
    repeat (2) @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    chk("midwait_ready_after", 32'(req_ready[1]), 32'd1);
    begin
      bit rose = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (resp_valid[1]) rose = 1'b1;
      end
      chk("midwait_no_resp", 32'(rose), 32'd0);
    end
    xact(1, 0, 32'd16, 32'h0, SIZE_WORD, 0, 32'h0000_1111, 0, 0, "ws_lw16_kept");

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
